// File: rtl/pulse_generator_multi_if.sv
// Control and status bundle for pulse_generator_multi: enable, clear, pulse length,
// per-channel levels in; per-channel pulses and sticky missed flags out.
interface pulse_generator_multi_if #(
    parameter int CHANNEL_COUNT = 4,
    parameter int COUNT_WIDTH   = 8
);
    logic                     clock_enable;
    logic                     clear;
    logic [COUNT_WIDTH-1:0]   pulse_length;
    logic [CHANNEL_COUNT-1:0] level_in;
    logic [CHANNEL_COUNT-1:0] pulse_out;
    logic [CHANNEL_COUNT-1:0] missed;

    modport master (
        output clock_enable, clear, pulse_length, level_in,
        input  pulse_out, missed
    );

    modport slave (
        input  clock_enable, clear, pulse_length, level_in,
        output pulse_out, missed
    );
endinterface

// File: rtl/pulse_generator_multi.sv
// Multi-channel edge-triggered pulse generator: each channel turns a detected edge on
// its level input into a pulse of pulse_length enabled cycles, timed by a down-counter.
module pulse_generator_multi #(
    parameter int CHANNEL_COUNT = 4,
    parameter int COUNT_WIDTH   = 8,
    parameter     EDGE_TYPE     = "POS",
    parameter int RETRIGGER     = 0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    pulse_generator_multi_if.slave    bus
);
    localparam bit IS_POS = (EDGE_TYPE == "POS");
    localparam bit IS_NEG = (EDGE_TYPE == "NEG");
    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

    logic [CHANNEL_COUNT-1:0] level_prev;
    logic [CHANNEL_COUNT-1:0] primed;
    logic [CHANNEL_COUNT-1:0] missed_r;
    logic [CHANNEL_COUNT-1:0] edge_det;
    logic [COUNT_WIDTH-1:0]   count [CHANNEL_COUNT];

    assign bus.missed = missed_r;

    for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_ch
        // An unprimed channel has no trustworthy previous level, so it never reports an edge.
        if (IS_POS) begin : g_pos
            assign edge_det[i] = primed[i] & bus.level_in[i] & ~level_prev[i];
        end else if (IS_NEG) begin : g_neg
            assign edge_det[i] = primed[i] & ~bus.level_in[i] & level_prev[i];
        end else begin : g_any
            assign edge_det[i] = primed[i] & (bus.level_in[i] ^ level_prev[i]);
        end

        assign bus.pulse_out[i] = (count[i] != CNT_ZERO);

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                count[i]      <= CNT_ZERO;
                level_prev[i] <= 1'b0;
                primed[i]     <= 1'b0;
                missed_r[i]   <= 1'b0;
            end else if (bus.clear) begin
                count[i]    <= CNT_ZERO;
                primed[i]   <= 1'b0;
                missed_r[i] <= 1'b0;
            end else if (bus.clock_enable) begin
                level_prev[i] <= bus.level_in[i];
                primed[i]     <= 1'b1;
                if (edge_det[i]) begin
                    // Without retrigger, only an idle counter or the final pulse cycle may reload.
                    if (count[i] == CNT_ZERO || count[i] == CNT_ONE || RETRIGGER != 0) begin
                        count[i] <= bus.pulse_length;
                    end else begin
                        count[i]    <= count[i] - CNT_ONE;
                        missed_r[i] <= 1'b1;
                    end
                end else if (count[i] != CNT_ZERO) begin
                    count[i] <= count[i] - CNT_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_pulse_generator_multi.sv
// Directed bench: four generator variants (POS/no-retrigger, ANY/no-retrigger,
// ANY/retrigger, NEG/no-retrigger) share one stimulus stream, each with its own expectations.
module tb_pulse_generator_multi;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       ce;
    logic       clr;
    logic [7:0] len;
    logic [3:0] lvl;
    int         total = 0;
    int         bad   = 0;

    pulse_generator_multi_if #(.CHANNEL_COUNT(4), .COUNT_WIDTH(8)) if_pos ();
    pulse_generator_multi_if #(.CHANNEL_COUNT(4), .COUNT_WIDTH(8)) if_any0 ();
    pulse_generator_multi_if #(.CHANNEL_COUNT(4), .COUNT_WIDTH(8)) if_any1 ();
    pulse_generator_multi_if #(.CHANNEL_COUNT(4), .COUNT_WIDTH(8)) if_neg ();

    assign if_pos.clock_enable  = ce;
    assign if_pos.clear         = clr;
    assign if_pos.pulse_length  = len;
    assign if_pos.level_in      = lvl;
    assign if_any0.clock_enable = ce;
    assign if_any0.clear        = clr;
    assign if_any0.pulse_length = len;
    assign if_any0.level_in     = lvl;
    assign if_any1.clock_enable = ce;
    assign if_any1.clear        = clr;
    assign if_any1.pulse_length = len;
    assign if_any1.level_in     = lvl;
    assign if_neg.clock_enable  = ce;
    assign if_neg.clear         = clr;
    assign if_neg.pulse_length  = len;
    assign if_neg.level_in      = lvl;

    pulse_generator_multi #(.CHANNEL_COUNT(4), .COUNT_WIDTH(8), .EDGE_TYPE("POS"), .RETRIGGER(0))
        u_pos (.clock(clock), .reset_n(reset_n), .bus(if_pos));
    pulse_generator_multi #(.CHANNEL_COUNT(4), .COUNT_WIDTH(8), .EDGE_TYPE("ANY"), .RETRIGGER(0))
        u_any0 (.clock(clock), .reset_n(reset_n), .bus(if_any0));
    pulse_generator_multi #(.CHANNEL_COUNT(4), .COUNT_WIDTH(8), .EDGE_TYPE("ANY"), .RETRIGGER(1))
        u_any1 (.clock(clock), .reset_n(reset_n), .bus(if_any1));
    pulse_generator_multi #(.CHANNEL_COUNT(4), .COUNT_WIDTH(8), .EDGE_TYPE("NEG"), .RETRIGGER(0))
        u_neg (.clock(clock), .reset_n(reset_n), .bus(if_neg));

    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Pulse outputs of all four variants in order pos, any0, any1, neg.
    task automatic chk_p(input string tag, input logic [3:0] p, input logic [3:0] a0,
                         input logic [3:0] a1, input logic [3:0] n);
        chk({tag, ".pos"},  if_pos.pulse_out,  p);
        chk({tag, ".any0"}, if_any0.pulse_out, a0);
        chk({tag, ".any1"}, if_any1.pulse_out, a1);
        chk({tag, ".neg"},  if_neg.pulse_out,  n);
    endtask

    task automatic chk_m(input string tag, input logic [3:0] p, input logic [3:0] a0,
                         input logic [3:0] a1, input logic [3:0] n);
        chk({tag, ".m_pos"},  if_pos.missed,  p);
        chk({tag, ".m_any0"}, if_any0.missed, a0);
        chk({tag, ".m_any1"}, if_any1.missed, a1);
        chk({tag, ".m_neg"},  if_neg.missed,  n);
    endtask

    initial begin
        reset_n = 1'b0;
        ce      = 1'b1;
        clr     = 1'b0;
        len     = 8'd3;
        lvl     = 4'hF;
        tick(2);
        chk_p("reset", 4'h0, 4'h0, 4'h0, 4'h0);
        chk_m("reset", 4'h0, 4'h0, 4'h0, 4'h0);

        // High level through reset: priming only, then a falling edge
        reset_n = 1'b1;
        tick(1);
        chk_p("prime", 4'h0, 4'h0, 4'h0, 4'h0);
        tick(1);
        chk_p("held_high", 4'h0, 4'h0, 4'h0, 4'h0);
        lvl = 4'h0;
        tick(1);
        chk_p("fall_c1", 4'h0, 4'hF, 4'hF, 4'hF);
        tick(2);
        chk_p("fall_c3", 4'h0, 4'hF, 4'hF, 4'hF);
        tick(1);
        chk_p("fall_end", 4'h0, 4'h0, 4'h0, 4'h0);

        // ch0 rise, L=3
        lvl = 4'h1;
        tick(1);
        chk_p("rise_c1", 4'h1, 4'h1, 4'h1, 4'h0);
        tick(2);
        chk_p("rise_c3", 4'h1, 4'h1, 4'h1, 4'h0);
        tick(1);
        chk_p("rise_end", 4'h0, 4'h0, 4'h0, 4'h0);
        lvl = 4'h0;
        tick(1);
        chk_p("ch0_fall", 4'h0, 4'h1, 4'h1, 4'h1);
        tick(3);
        chk_p("ch0_fall_end", 4'h0, 4'h0, 4'h0, 4'h0);

        // ch1 edges two cycles apart, L=5
        len = 8'd5;
        lvl = 4'h2;
        tick(1);
        chk_p("dbl_c1", 4'h2, 4'h2, 4'h2, 4'h0);
        tick(1);
        lvl = 4'h0;
        tick(1);
        chk_p("dbl_c3", 4'h2, 4'h2, 4'h2, 4'h2);
        chk_m("dbl_c3", 4'h0, 4'h2, 4'h0, 4'h0);
        tick(2);
        chk_p("dbl_c5", 4'h2, 4'h2, 4'h2, 4'h2);
        tick(1);
        chk_p("dbl_c6", 4'h0, 4'h0, 4'h2, 4'h2);
        tick(1);
        chk_p("dbl_c7", 4'h0, 4'h0, 4'h2, 4'h2);
        tick(1);
        chk_p("dbl_end", 4'h0, 4'h0, 4'h0, 4'h0);
        chk_m("dbl_end", 4'h0, 4'h2, 4'h0, 4'h0);

        // ch2 edge on last pulse cycle reloads without setting missed, L=2
        len = 8'd2;
        lvl = 4'h4;
        tick(2);
        chk_p("last_c2", 4'h4, 4'h4, 4'h4, 4'h0);
        lvl = 4'h0;
        tick(1);
        chk_p("last_reload", 4'h0, 4'h4, 4'h4, 4'h4);
        chk_m("last_reload", 4'h0, 4'h2, 4'h0, 4'h0);
        tick(1);
        chk_p("last_c4", 4'h0, 4'h4, 4'h4, 4'h4);
        tick(1);
        chk_p("last_end", 4'h0, 4'h0, 4'h0, 4'h0);

        // ch3, L=4, enable low for three cycles, pulse_length changed mid-pulse
        len = 8'd4;
        lvl = 4'h8;
        tick(1);
        chk_p("ce_c1", 4'h8, 4'h8, 4'h8, 4'h0);
        len = 8'd1;
        tick(1);
        ce = 1'b0;
        tick(3);
        chk_p("ce_hold", 4'h8, 4'h8, 4'h8, 4'h0);
        ce = 1'b1;
        tick(2);
        chk_p("ce_c7", 4'h8, 4'h8, 4'h8, 4'h0);
        tick(1);
        chk_p("ce_end", 4'h0, 4'h0, 4'h0, 4'h0);

        // Reset in the middle of an L=6 pulse
        len = 8'd6;
        lvl = 4'h9;
        tick(2);
        chk_p("rst_pre", 4'h1, 4'h1, 4'h1, 4'h0);
        #2 reset_n = 1'b0;
        #1;
        chk_p("rst_async", 4'h0, 4'h0, 4'h0, 4'h0);
        chk_m("rst_async", 4'h0, 4'h0, 4'h0, 4'h0);
        tick(1);
        reset_n = 1'b1;
        tick(2);
        chk_p("rst_after", 4'h0, 4'h0, 4'h0, 4'h0);

        // Clear mid-pulse with a simultaneous edge, then held high
        lvl = 4'h8;
        tick(2);
        chk_p("clr_pre", 4'h0, 4'h1, 4'h1, 4'h1);
        clr = 1'b1;
        lvl = 4'h9;
        tick(1);
        chk_p("clr_now", 4'h0, 4'h0, 4'h0, 4'h0);
        lvl = 4'h0;
        tick(1);
        chk_p("clr_held", 4'h0, 4'h0, 4'h0, 4'h0);
        clr = 1'b0;
        tick(1);
        chk_p("clr_prime", 4'h0, 4'h0, 4'h0, 4'h0);

        // Clear with enable low still drops missed
        len = 8'd5;
        lvl = 4'h1;
        tick(2);
        lvl = 4'h0;
        tick(1);
        chk_m("miss_set", 4'h0, 4'h1, 4'h0, 4'h0);
        ce  = 1'b0;
        clr = 1'b1;
        tick(1);
        chk_p("clr_ce0", 4'h0, 4'h0, 4'h0, 4'h0);
        chk_m("clr_ce0", 4'h0, 4'h0, 4'h0, 4'h0);
        ce  = 1'b1;
        clr = 1'b0;
        tick(1);

        // Zero length: no pulse, no missed
        len = 8'd0;
        lvl = 4'h1;
        tick(1);
        chk_p("len0", 4'h0, 4'h0, 4'h0, 4'h0);
        chk_m("len0", 4'h0, 4'h0, 4'h0, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pulse_generator_multi.md
PULSE_GENERATOR_MULTI -- requirements
Module: pulse_generator_multi

Interface
REQ-001 Parameter CHANNEL_COUNT, default 4: number of independent channels, minimum 1.
REQ-002 Parameter COUNT_WIDTH, default 8: width of the pulse-length counter, minimum 1.
REQ-003 Parameter EDGE_TYPE, default "POS": detected edge, one of "POS", "NEG" or "ANY"; applies to all channels.
REQ-004 Parameter RETRIGGER, default 0: 1 = an edge during a pulse reloads the counter; 0 = such an edge is ignored and flagged.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 clock_enable  input  1  when low, all state holds, except for clear.
REQ-008 clear  input  1  synchronous clear; acts regardless of clock_enable.
REQ-009 pulse_length  input  COUNT_WIDTH  pulse length in cycles; sampled only when a counter loads.
REQ-010 level_in  input  CHANNEL_COUNT  per-channel level; synchronous to clock.
REQ-011 pulse_out  output  CHANNEL_COUNT  per-channel pulse, driven from registered state.
REQ-012 missed  output  CHANNEL_COUNT  per-channel sticky flag: an edge was ignored (RETRIGGER=0 only).

Function
REQ-013 Per-channel state SHALL be: level_prev (1 bit), primed (1 bit), count (COUNT_WIDTH bits), missed (1 bit).
REQ-014 pulse_out[i] SHALL equal (count[i] != 0) and SHALL be derived only from registers.
REQ-015 On an enabled cycle with primed[i]=0, the channel SHALL load level_prev[i] <= level_in[i] and set primed[i] <= 1, with no edge detection.
REQ-016 With primed[i]=1, the channel SHALL detect an edge as follows:
- POS: level_in=1 and level_prev=0.
- NEG: level_in=0 and level_prev=1.
- ANY: level_in != level_prev.
REQ-017 level_prev[i] SHALL update to level_in[i] on every enabled cycle.
REQ-018 Latency: an edge sampled in cycle N with pulse_length=L>0 SHALL load count <= L, so pulse_out is high for cycles N+1 through N+L inclusive, counting enabled cycles only.
REQ-019 pulse_length=0 at load time SHALL produce no pulse and SHALL NOT set missed.
REQ-020 On an enabled cycle with count != 0 and no load, count SHALL decrement by 1; count SHALL never wrap below 0.
REQ-021 When clock_enable is low, count, level_prev, primed and missed SHALL hold; pulse_out SHALL hold its value and stretch accordingly.
REQ-022 With RETRIGGER=1, an edge while count != 0 SHALL reload count <= pulse_length; the pulse extends with no low cycle in between.
REQ-023 With RETRIGGER=0, an edge while count > 1 SHALL be ignored and SHALL set missed[i] <= 1.
REQ-024 With RETRIGGER=0, an edge while count == 1 (last pulse cycle) SHALL load a new pulse; pulse_out stays high continuously.
REQ-025 missed[i] SHALL be sticky; only clear or reset SHALL return it to 0.
REQ-026 Channels SHALL be fully independent; an event on one channel SHALL NOT affect any other.
REQ-027 clear=1 SHALL set, at the next clock edge for all channels: count=0, missed=0, primed=0.
- clear SHALL take priority over simultaneous edges and clock_enable.
- clear held high SHALL suppress all pulses.
REQ-028 Changing pulse_length mid-pulse SHALL NOT alter a running count.

Reset
REQ-029 reset_n=0 SHALL immediately and asynchronously force, for every channel: count=0, pulse_out=0, missed=0, primed=0, level_prev=0.
REQ-030 Deassertion of reset_n SHALL be synchronous to clock; the first enabled cycle after reset only primes (REQ-015), so a level already high at reset never produces a pulse.
REQ-031 Reset asserted mid-pulse SHALL terminate the pulse immediately; no residual pulse SHALL follow release.

Verification
REQ-032 Scenario 1: POS, L=3, ch0 rises in cycle 10 -> pulse_out[0] high in cycles 11-13 only; other channels stay 0.
REQ-033 Scenario 2: RETRIGGER=0, L=5, ch1 rises at cycle 0 and falls at 2, ANY mode:
- second edge at cycle 2 is ignored, missed[1]=1;
- pulse high for cycles 1-5;
- missed stays 1 until clear.
REQ-034 Scenario 3: RETRIGGER=1, ANY, L=4, edges at cycles 0 and 2 -> pulse_out high cycles 1-6 continuously; missed stays 0.
REQ-035 Scenario 4: L=4, edge at cycle 0, clock_enable low for cycles 2-4 -> pulse high cycles 1-7 (4 enabled cycles); low from cycle 8.
REQ-036 Scenario 5: level_in=all ones during reset, reset_n released, then held -> no pulse on any channel; first falling edge in NEG mode pulses for L cycles.
REQ-037 Scenario 6: reset_n pulsed low at cycle 2 of an L=6 pulse -> pulse_out=0 in the same cycle, stays 0; clear=1 mid-pulse -> pulse_out=0 the next cycle.
